// File: rtl/counter_ctrl_pkg.sv
// Shared types and helpers for the counter_ctrl sequencing controller.
package counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Value at which counting in the given direction terminates.
    function automatic int term_value(input logic up, input int modulus);
        return up ? (modulus - 1) : 0;
    endfunction

endpackage

// File: rtl/counter_ctrl_if.sv
// Control/status bundle between the board-level inputs and counter_ctrl.
interface counter_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             START;
    logic             STOP;
    logic             HOLD;
    logic             UP;
    logic             LOAD;
    logic [WIDTH-1:0] LOAD_VAL;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] Qn;
    logic             TC;
    logic             BUSY;
    logic             DONE;

    modport master (
        output START, STOP, HOLD, UP, LOAD, LOAD_VAL,
        input  Q, Qn, TC, BUSY, DONE
    );

    modport slave (
        input  START, STOP, HOLD, UP, LOAD, LOAD_VAL,
        output Q, Qn, TC, BUSY, DONE
    );
endinterface

// File: rtl/counter_ctrl_count_reg.sv
// WIDTH-bit count register with synchronous clear, parallel load and +/-1 step.
module count_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             clr_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             step_i,
    input  logic             up_i,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] qn_o
);
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Load outranks step; the controller never asserts both.
    always_comb begin
        q_d = q_q;
        if (load_i) begin
            q_d = load_val_i;
        end else if (step_i) begin
            q_d = up_i ? (q_q + WIDTH'(1)) : (q_q - WIDTH'(1));
        end
    end

    always_ff @(posedge clk_i) begin
        if (!clr_ni) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o  = q_q;
    assign qn_o = ~q_q;
endmodule

// File: rtl/counter_ctrl.sv
// Start/stop/hold sequencer for a mod-MODULUS up/down counter.
// Define COUNTER_CTRL_AUTO_RELOAD_EN to wrap at terminal count instead of stopping in DONE.
module counter_ctrl
    import counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic           CLK,
    input  logic           RESET,
    counter_ctrl_if.slave  bus
);
`ifdef COUNTER_CTRL_AUTO_RELOAD_EN
    localparam bit AUTO_RELOAD = 1'b1;
`else
    localparam bit AUTO_RELOAD = 1'b0;
`endif

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(term_value(1'b1, MODULUS));
    localparam logic [WIDTH-1:0] MIN_VAL = WIDTH'(term_value(1'b0, MODULUS));
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);

    state_e           state_q;
    state_e           state_d;
    logic             tc_q;
    logic             tc_d;
    logic             busy_q;
    logic             busy_d;
    logic             done_q;
    logic             done_d;

    logic             ld_en;
    logic [WIDTH-1:0] ld_val;
    logic             step_en;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qn;
    logic             at_term;
    logic [WIDTH-1:0] load_sat;
    logic [WIDTH-1:0] restart_val;

    assign at_term     = bus.UP ? (q == MAX_VAL) : (q == MIN_VAL);
    assign load_sat    = ({1'b0, bus.LOAD_VAL} >= MOD_EXT) ? MAX_VAL : bus.LOAD_VAL;
    assign restart_val = bus.UP ? MIN_VAL : MAX_VAL;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= ST_IDLE;
            tc_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tc_q    <= tc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Priority: STOP > LOAD > START > HOLD > count.
    always_comb begin
        state_d = state_q;
        if (bus.STOP) begin
            state_d = ST_IDLE;
        end else if (bus.LOAD) begin
            if (state_q == ST_DONE) state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   if (bus.START) state_d = ST_RUN;
                ST_RUN: begin
                    if (bus.HOLD)                      state_d = ST_PAUSED;
                    else if (at_term && !AUTO_RELOAD)  state_d = ST_DONE;
                end
                ST_PAUSED: if (!bus.HOLD) state_d = ST_RUN;
                ST_DONE:   if (bus.START) state_d = ST_RUN;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Leaving PAUSED never steps, which gives the one-cycle resume bubble.
    always_comb begin
        ld_en   = 1'b0;
        ld_val  = load_sat;
        step_en = 1'b0;
        tc_d    = 1'b0;
        if (bus.STOP) begin
            ld_en = 1'b0;
        end else if (bus.LOAD) begin
            ld_en = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (!bus.HOLD) begin
                        if (at_term) begin
                            tc_d = 1'b1;
                            if (AUTO_RELOAD) begin
                                ld_en  = 1'b1;
                                ld_val = restart_val;
                            end
                        end else begin
                            step_en = 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.START) begin
                        ld_en  = 1'b1;
                        ld_val = restart_val;
                    end
                end
                default: ld_en = 1'b0;
            endcase
        end
        busy_d = (state_d == ST_RUN) || (state_d == ST_PAUSED);
        done_d = !AUTO_RELOAD && (state_d == ST_DONE);
    end

    count_reg #(
        .WIDTH (WIDTH)
    ) u_count_reg (
        .clk_i      (CLK),
        .clr_ni     (RESET),
        .load_i     (ld_en),
        .load_val_i (ld_val),
        .step_i     (step_en),
        .up_i       (bus.UP),
        .q_o        (q),
        .qn_o       (qn)
    );

    assign bus.Q    = q;
    assign bus.Qn   = qn;
    assign bus.TC   = tc_q;
    assign bus.BUSY = busy_q;
    assign bus.DONE = done_q;
endmodule
